// File: rtl/pe_ipad_ctrl_pkg.sv
// Shared types and defaults for the PE input-scratchpad sequencer.
package PECfg;
  localparam int IPadSize = 16;
  localparam int PConfDWd = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } IPadCtrlState;
endpackage

// File: rtl/pe_ipad_ctrl_if.sv
// Port bundle between the PE input port / fetch stage and the IPAD sequencer.
interface pe_ipad_ctrl_if
  import PECfg::*;
#(
    parameter int IPadSize = PECfg::IPadSize,
    parameter int CfgWd    = PECfg::PConfDWd
);
    localparam int AWd = $clog2(IPadSize);

    logic [CfgWd-1:0] i_cfg_win;
    logic [CfgWd-1:0] i_cfg_step;
    logic [CfgWd-1:0] i_cfg_npix;
    logic             i_start;
    logic             i_stall;
    logic             i_flush;
    // Both handshakes transfer on a cycle where valid and ready are high together;
    // ready never looks at valid, and o_wen/o_ren are the transfer strobes.
    logic             i_ipix_valid;
    logic             o_ipix_ready;
    logic             i_ipix_zero;
    logic             o_wen;
    logic [AWd-1:0]   o_waddr;
    logic             i_rd_ready;
    logic             o_ren;
    logic [AWd-1:0]   o_raddr;
    logic             o_rzero;
    logic             o_rlast;
    logic             o_busy;
    logic             o_done;
    logic             o_cfg_err;
    IPadCtrlState     o_state;

    modport slave (
        input  i_cfg_win, i_cfg_step, i_cfg_npix, i_start, i_stall, i_flush,
        input  i_ipix_valid, i_ipix_zero, i_rd_ready,
        output o_ipix_ready, o_wen, o_waddr, o_ren, o_raddr, o_rzero, o_rlast,
        output o_busy, o_done, o_cfg_err, o_state
    );

    modport master (
        output i_cfg_win, i_cfg_step, i_cfg_npix, i_start, i_stall, i_flush,
        output i_ipix_valid, i_ipix_zero, i_rd_ready,
        input  o_ipix_ready, o_wen, o_waddr, o_ren, o_raddr, o_rzero, o_rlast,
        input  o_busy, o_done, o_cfg_err, o_state
    );
endinterface

// File: rtl/pe_ipad_ctrl_ptr_wrap.sv
// Modulo-IPadSize pointer add; the depth need not be a power of two.
module ipad_ptr_wrap
  import PECfg::*;
#(
    parameter int IPadSize = PECfg::IPadSize,
    parameter int AWd      = $clog2(IPadSize)
) (
    input  logic [AWd-1:0] i_ptr,
    input  logic [AWd:0]   i_inc,
    output logic [AWd-1:0] o_ptr
);
    logic [AWd:0] sum;

    // i_ptr < IPadSize and i_inc <= IPadSize, so one conditional subtract suffices.
    assign sum   = {1'b0, i_ptr} + i_inc;
    assign o_ptr = (sum >= (AWd+1)'(IPadSize)) ? AWd'(sum - (AWd+1)'(IPadSize))
                                               : sum[AWd-1:0];
endmodule

// File: rtl/pe_ipad_ctrl.sv
// IPAD sequencer: allocates write slots for incoming pixels and replays overlapping
// sliding windows to the fetch stage, retiring `step` entries per output pixel.
module pe_ipad_ctrl
  import PECfg::*;
#(
    parameter int IPadSize = PECfg::IPadSize,
    parameter int CfgWd    = PECfg::PConfDWd
) (
    input logic           i_clk,
    input logic           i_rstn,
    pe_ipad_ctrl_if.slave bus
);
    localparam int AWd  = $clog2(IPadSize);
    localparam int WcWd = 2 * CfgWd;

    IPadCtrlState     state_q, state_d;
    logic [CfgWd-1:0] win_q, step_q, npix_q, pcnt_q;
    logic [AWd-1:0]   wptr_q, base_q;
    logic [AWd:0]     k_q, occ_q;
    logic [WcWd-1:0]  wcnt_q, wlim;
    logic [IPadSize-1:0] flag_q;
    logic             cfg_err_q;
    logic             cfg_legal, load, run, act, ready, wen, ren;
    logic             win_end, last_pix, retire;
    logic [AWd-1:0]   wptr_inc, base_inc, raddr;

    assign cfg_legal = (bus.i_cfg_step != '0) && (bus.i_cfg_step <= bus.i_cfg_win) &&
                       (32'(bus.i_cfg_win) <= 32'(IPadSize)) && (bus.i_cfg_npix != '0);
    assign load      = (state_q == IDLE) && bus.i_start && cfg_legal;

    // Total entries the job consumes: first window plus one step per further pixel.
    assign wlim     = WcWd'(win_q) + WcWd'(npix_q - CfgWd'(1)) * WcWd'(step_q);
    assign run      = (state_q == RUN);
    assign act      = run && !bus.i_stall && !bus.i_flush;
    assign ready    = act && (occ_q < (AWd+1)'(IPadSize)) && (wcnt_q < wlim);
    assign wen      = ready && bus.i_ipix_valid;
    assign ren      = act && (k_q < occ_q) && bus.i_rd_ready;
    assign win_end  = (k_q == (AWd+1)'(win_q - CfgWd'(1)));
    assign last_pix = (pcnt_q == npix_q - CfgWd'(1));
    assign retire   = ren && win_end && !last_pix;

    ipad_ptr_wrap #(.IPadSize(IPadSize), .AWd(AWd)) u_wptr_wrap (
        .i_ptr(wptr_q), .i_inc((AWd+1)'(1)), .o_ptr(wptr_inc));
    ipad_ptr_wrap #(.IPadSize(IPadSize), .AWd(AWd)) u_base_wrap (
        .i_ptr(base_q), .i_inc((AWd+1)'(step_q)), .o_ptr(base_inc));
    ipad_ptr_wrap #(.IPadSize(IPadSize), .AWd(AWd)) u_raddr_wrap (
        .i_ptr(base_q), .i_inc(k_q), .o_ptr(raddr));

    assign bus.o_ipix_ready = ready;
    assign bus.o_wen        = wen;
    assign bus.o_waddr      = wptr_q;
    assign bus.o_ren        = ren;
    assign bus.o_raddr      = raddr;
    assign bus.o_rzero      = flag_q[raddr];
    assign bus.o_rlast      = run && win_end;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_done       = (state_q == DONE);
    assign bus.o_cfg_err    = cfg_err_q;
    assign bus.o_state      = state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = RUN;
            RUN:     if (ren && win_end && last_pix) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.i_flush)      state_d = IDLE;
        else if (bus.i_stall) state_d = state_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= !bus.i_flush && !bus.i_stall && (state_q == IDLE) &&
                         bus.i_start && !cfg_legal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            win_q  <= '0;
            step_q <= '0;
            npix_q <= '0;
            pcnt_q <= '0;
            wptr_q <= '0;
            base_q <= '0;
            k_q    <= '0;
            occ_q  <= '0;
            wcnt_q <= '0;
            flag_q <= '0;
        end else if (bus.i_flush) begin
            pcnt_q <= '0;
            wptr_q <= '0;
            base_q <= '0;
            k_q    <= '0;
            occ_q  <= '0;
            wcnt_q <= '0;
        end else if (!bus.i_stall) begin
            if (load) begin
                win_q  <= bus.i_cfg_win;
                step_q <= bus.i_cfg_step;
                npix_q <= bus.i_cfg_npix;
                pcnt_q <= '0;
                wptr_q <= '0;
                base_q <= '0;
                k_q    <= '0;
                occ_q  <= '0;
                wcnt_q <= '0;
            end else if (run) begin
                if (wen) begin
                    flag_q[wptr_q] <= bus.i_ipix_zero;
                    wptr_q         <= wptr_inc;
                    wcnt_q         <= wcnt_q + WcWd'(1);
                end
                if (ren) begin
                    if (win_end) begin
                        k_q    <= '0;
                        pcnt_q <= pcnt_q + CfgWd'(1);
                        if (!last_pix) base_q <= base_inc;
                    end else begin
                        k_q <= k_q + (AWd+1)'(1);
                    end
                end
                // A write and a retirement in the same cycle net to +1-step.
                occ_q <= occ_q + (AWd+1)'(wen) - (retire ? (AWd+1)'(step_q) : '0);
            end
        end
    end
endmodule

// File: doc/pe_ipad_ctrl.md
# pe_ipad_ctrl

Sequencer for the PE input scratchpad (IPAD), a circular 2-port register file. It accepts the incoming input-pixel stream and allocates write addresses. It then replays each sliding window of `Pch*R` entries to the fetch stage, retiring `Pch*U` entries per output pixel so that overlapping entries are reused. It also keeps a per-entry zero flag for zero-skip. It sits between the PE input port and the IPAD `RF_2F` instance and drives that instance's read/write controls directly.

## Interface
- `IPadSize`, 16: IPAD depth in entries (any value ≥ 2).
- `CfgWd`, 8: configuration field width.
- `AWd`, `$clog2(IPadSize)`: address width (derived).

- `i_clk` in 1: clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_cfg_win` in CfgWd: window length in entries (`Pch*R`).
- `i_cfg_step` in CfgWd: entries retired per output pixel (`Pch*U`).
- `i_cfg_npix` in CfgWd: output pixels per job.
- `i_start` in 1: start job; configuration is sampled on this cycle.
- `i_stall` in 1: freeze all state.
- `i_flush` in 1: synchronous abort to IDLE.
- `i_ipix_valid` in 1: input pixel offered.
- `o_ipix_ready` out 1: IPAD can accept the pixel.
- `i_ipix_zero` in 1: offered pixel is zero.
- `o_wen` out 1: IPAD write enable.
- `o_waddr` out AWd: IPAD write address.
- `i_rd_ready` in 1: fetch stage accepts a read this cycle.
- `o_ren` out 1: IPAD read enable.
- `o_raddr` out AWd: IPAD read address.
- `o_rzero` out 1: zero flag of the entry at `o_raddr`.
- `o_rlast` out 1: this read is the last entry of its window.
- `o_busy` out 1: job in progress.
- `o_done` out 1: one-cycle pulse at job end.
- `o_cfg_err` out 1: one-cycle pulse when `i_start` carries an illegal configuration.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - A legal `i_start` loads the configuration, clears `wptr`, `base`, `k`, `occ`, `wcnt` and `pcnt`, and moves to RUN.
  - Legal means `1 ≤ step ≤ win ≤ IPadSize` and `npix ≥ 1`. An illegal start raises `o_cfg_err` and the block stays in IDLE.
- **Write side (RUN only):**
  - `o_ipix_ready = occ < IPadSize && wcnt < win + (npix-1)*step`.
  - `o_wen = valid & ready` and `o_waddr = wptr`.
  - On a write, `flag[wptr] <= i_ipix_zero`, `wptr` advances with wrap, and `wcnt` increments.
- **Read side (RUN only):**
  - `o_ren = k < occ && i_rd_ready`.
  - `o_raddr = (base + k) mod IPadSize`, `o_rzero = flag[o_raddr]`, `o_rlast = (k == win-1)`.
  - On a read with `k < win-1`, `k` increments.
  - On a read with `k == win-1`, `k` returns to 0 and `pcnt` increments. If `pcnt` was `npix-1`, the state goes to DONE. Otherwise `base += step` (with wrap) and `occ -= step`.
- **occ update:** `occ` adds the write and subtracts the retirement in the same cycle, so a simultaneous write and retire nets to `+1-step`.
- **Wrap arithmetic:** `x + n ≥ IPadSize ? x + n - IPadSize : x + n`. No power-of-2 assumption is made.
- **DONE:** `o_done` is high for one cycle, then the state returns to IDLE. `i_start` is ignored outside IDLE.
- **Stall:** freezes all registers and forces `o_ipix_ready`, `o_ren` and `o_wen` to 0.
- **Flush:** takes priority over stall and start. It forces IDLE, clears all counters, and produces no `o_done`.
- **Flags:** the flag array is not cleared on start. Flags are always written before they can be read.
- **Widths:** `occ` and `k` are AWd+1 bits. `wcnt` is 2·CfgWd bits.

## Timing
- `o_ipix_ready`, `o_ren`, `o_raddr`, `o_rzero`, `o_rlast` and `o_waddr` are combinational from registers plus `i_rd_ready`/`i_ipix_valid`/`i_stall`/`i_flush`. There is no combinational path between the write and read handshakes.
- An entry written in cycle t is readable no earlier than t+1, because `occ` is registered.
- The `o_busy` reset value is 0. It is high from the cycle after a legal start through the DONE cycle.
- Reset values: all outputs 0 and state IDLE.
- Best case with continuous input: first read at start+2. Job ends `win*npix` read cycles after the first read, plus 1 cycle to DONE.
- Asynchronous reset mid-job immediately returns the block to IDLE with all outputs 0.

## Structure
- **Package (`PECfg`):**
  - `IPadCtrlState` enum (IDLE, RUN, DONE).
  - `IPadSize`.
  - `PConfDWd` reused as CfgWd.
- **Sub-module `ipad_ptr_wrap`:** a combinational mod-add, instanced for `wptr`, `base` and `raddr`.
- The flag array is a local register vector of `IPadSize` bits.

## Test plan
- `win=6, step=2, npix=3`, continuous input, `rd_ready=1` → exactly 10 writes. `raddr` sequences are 0-5, 2-7, 4-9. `o_rlast` is seen 3 times, and `o_done` follows the last read by 1 cycle.
- `win=16, step=4, npix=2` → `ready` drops at `occ=16` and reasserts the cycle after the first `rlast`. Total 20 writes, with the 17th at `waddr=0`.
- `win=12, step=4, npix=3` → the third window reads 8..15 then 0..3, with `rlast` at `raddr=3`.
- Zero on writes to addresses 1 and 3, `win=4, step=4, npix=1` → `o_rzero` is high exactly on reads of 1 and 3.
- Stall for 3 cycles mid-window → no `ren`/`wen` and unchanged `raddr` during the stall. Flush at `k=2` → IDLE, no `o_done`. A new start then reads from `raddr=0`.
- Start with `step=0`, or `step=5, win=4` → `o_cfg_err` pulses, state stays IDLE, `o_busy` stays 0.
